id_ex_stage: RTL and testbench

ID/EX pipeline register for the ARC MIPS core, placed directly downstream of the opcode control decoder and the register file. It captures the decoder's control bundle, operands, immediate and register specifiers, and presents them to the execute stage one cycle later. It also detects load-use hazards and asserts a stall to PC/IF-ID, inserts bubbles on stall or flush, and keeps a saturating bubble counter.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands for EX,
// detects load-use hazards, inserts bubbles on stall/flush and counts them.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_idex_valid,
  input  logic              i_idex_regdst,
  input  logic              i_idex_branch,
  input  logic              i_idex_memread,
  input  logic              i_idex_memtoreg,
  input  logic              i_idex_memwrite,
  input  logic              i_idex_alusrc,
  input  logic              i_idex_regwrite,
  input  logic [1:0]        i_idex_aluop,
  input  logic [3:0]        i_idex_other,
  input  logic [DATA_W-1:0] i_idex_pc4,
  input  logic [DATA_W-1:0] i_idex_rdata1,
  input  logic [DATA_W-1:0] i_idex_rdata2,
  input  logic [DATA_W-1:0] i_idex_imm,
  input  logic [4:0]        i_idex_rs,
  input  logic [4:0]        i_idex_rt,
  input  logic [4:0]        i_idex_rd,
  input  logic              i_idex_flush,
  input  logic              i_idex_hold,
  output logic              o_idex_regdst,
  output logic              o_idex_branch,
  output logic              o_idex_memread,
  output logic              o_idex_memtoreg,
  output logic              o_idex_memwrite,
  output logic              o_idex_alusrc,
  output logic              o_idex_regwrite,
  output logic [1:0]        o_idex_aluop,
  output logic [3:0]        o_idex_other,
  output logic [DATA_W-1:0] o_idex_pc4,
  output logic [DATA_W-1:0] o_idex_rdata1,
  output logic [DATA_W-1:0] o_idex_rdata2,
  output logic [DATA_W-1:0] o_idex_imm,
  output logic [4:0]        o_idex_rs,
  output logic [4:0]        o_idex_rt,
  output logic [4:0]        o_idex_dst,
  output logic              o_idex_valid,
  output logic              o_idex_stall,
  output logic [CNT_W-1:0]  o_idex_bubbles
);

  localparam int CTL_W = 13;

  logic [CTL_W-1:0]  ctl_in;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
  logic [CNT_W-1:0]  bub_q, bub_d;
  logic              uses_rt, lu, load_en, bub_inc;

  assign ctl_in = {i_idex_regdst, i_idex_branch, i_idex_memread, i_idex_memtoreg,
                   i_idex_memwrite, i_idex_alusrc, i_idex_regwrite, i_idex_aluop, i_idex_other};

  // rt is only a true source for R-type, stores and branches
  assign uses_rt = i_idex_regdst | i_idex_memwrite | i_idex_branch;
  assign lu = valid_q & o_idex_memread & (dst_q != 5'd0) & i_idex_valid &
              ((dst_q == i_idex_rs) | ((dst_q == i_idex_rt) & uses_rt));
  assign o_idex_stall = lu & ~i_idex_flush;

  assign load_en = ~i_idex_flush & ~i_idex_hold & ~lu;
  assign bub_inc = i_idex_flush ? i_idex_valid : (~i_idex_hold & lu);

  always_comb begin
    valid_d  = valid_q;
    ctl_d    = ctl_q;
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    dst_d    = dst_q;
    if (i_idex_flush || (!i_idex_hold && lu)) begin
      valid_d = 1'b0;
      ctl_d   = '0;
    end else if (load_en) begin
      valid_d  = i_idex_valid;
      ctl_d    = i_idex_valid ? ctl_in : '0;
      pc4_d    = i_idex_pc4;
      rdata1_d = i_idex_rdata1;
      rdata2_d = i_idex_rdata2;
      imm_d    = i_idex_imm;
      rs_d     = i_idex_rs;
      rt_d     = i_idex_rt;
      dst_d    = i_idex_regdst ? i_idex_rd : i_idex_rt;
    end
  end

  // Saturating: sticks at all-ones instead of wrapping
  assign bub_d = (bub_inc && (bub_q != {CNT_W{1'b1}})) ? bub_q + CNT_W'(1) : bub_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      dst_q    <= '0;
      bub_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      dst_q    <= dst_d;
      bub_q    <= bub_d;
    end
  end

  assign {o_idex_regdst, o_idex_branch, o_idex_memread, o_idex_memtoreg,
          o_idex_memwrite, o_idex_alusrc, o_idex_regwrite, o_idex_aluop, o_idex_other} = ctl_q;
  assign o_idex_valid   = valid_q;
  assign o_idex_pc4     = pc4_q;
  assign o_idex_rdata1  = rdata1_q;
  assign o_idex_rdata2  = rdata2_q;
  assign o_idex_imm     = imm_q;
  assign o_idex_rs      = rs_q;
  assign o_idex_rt      = rt_q;
  assign o_idex_dst     = dst_q;
  assign o_idex_bubbles = bub_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/priority scenarios, then random traffic
// compared against a per-edge behavioural model of the EX stage contents.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_flush = 1'b0, in_hold = 1'b0;
  logic [12:0]   in_ctl = '0;
  logic [DW-1:0] in_pc4 = '0, in_rd1 = '0, in_rd2 = '0, in_imm = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;

  logic          o_regdst, o_branch, o_memread, o_memtoreg, o_memwrite, o_alusrc, o_regwrite;
  logic [1:0]    o_aluop;
  logic [3:0]    o_other;
  logic [DW-1:0] o_pc4, o_rd1, o_rd2, o_imm;
  logic [4:0]    o_rs, o_rt, o_dst;
  logic          o_valid, o_stall;
  logic [CW-1:0] o_bub;
  logic [12:0]   o_ctl;

  assign o_ctl = {o_regdst, o_branch, o_memread, o_memtoreg, o_memwrite, o_alusrc, o_regwrite, o_aluop, o_other};

  // Control word layout: {regdst,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop[1:0],other[3:0]}
  localparam logic [12:0] C_ADDI = 13'h00F0;
  localparam logic [12:0] C_LW   = 13'h06C0;
  localparam logic [12:0] C_RTYP = 13'h1060;
  localparam logic [12:0] C_SW   = 13'h0180;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_valid(in_valid),
    .i_idex_regdst(in_ctl[12]), .i_idex_branch(in_ctl[11]), .i_idex_memread(in_ctl[10]),
    .i_idex_memtoreg(in_ctl[9]), .i_idex_memwrite(in_ctl[8]), .i_idex_alusrc(in_ctl[7]),
    .i_idex_regwrite(in_ctl[6]), .i_idex_aluop(in_ctl[5:4]), .i_idex_other(in_ctl[3:0]),
    .i_idex_pc4(in_pc4), .i_idex_rdata1(in_rd1), .i_idex_rdata2(in_rd2), .i_idex_imm(in_imm),
    .i_idex_rs(in_rs), .i_idex_rt(in_rt), .i_idex_rd(in_rd),
    .i_idex_flush(in_flush), .i_idex_hold(in_hold),
    .o_idex_regdst(o_regdst), .o_idex_branch(o_branch), .o_idex_memread(o_memread),
    .o_idex_memtoreg(o_memtoreg), .o_idex_memwrite(o_memwrite), .o_idex_alusrc(o_alusrc),
    .o_idex_regwrite(o_regwrite), .o_idex_aluop(o_aluop), .o_idex_other(o_other),
    .o_idex_pc4(o_pc4), .o_idex_rdata1(o_rd1), .o_idex_rdata2(o_rd2), .o_idex_imm(o_imm),
    .o_idex_rs(o_rs), .o_idex_rt(o_rt), .o_idex_dst(o_dst),
    .o_idex_valid(o_valid), .o_idex_stall(o_stall), .o_idex_bubbles(o_bub)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of what EX should hold; data is "known" only after a real load
  logic          m_valid, m_known;
  logic [12:0]   m_ctl;
  logic [DW-1:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [4:0]    m_rs, m_rt, m_dst;
  int            m_bub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_known = 1; m_ctl = '0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0;
    m_imm = '0; m_rs = '0; m_rt = '0; m_dst = '0; m_bub = 0;
  endtask

  function automatic bit model_hazard();
    bit is_load, rt_src;
    is_load = m_valid && m_ctl[10] && (m_dst != 0);
    rt_src  = in_ctl[12] || in_ctl[8] || in_ctl[11];
    return is_load && in_valid && ((m_dst == in_rs) || ((m_dst == in_rt) && rt_src));
  endfunction

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (in_flush) begin
      m_valid = 0; m_ctl = '0; m_known = 0;
      if (in_valid) m_bub = (m_bub < 15) ? m_bub + 1 : 15;
    end else if (in_hold) begin
      // frozen
    end else if (hz) begin
      m_valid = 0; m_ctl = '0; m_known = 0;
      m_bub = (m_bub < 15) ? m_bub + 1 : 15;
    end else begin
      m_valid = in_valid; m_ctl = in_valid ? in_ctl : 13'h0;
      m_pc4 = in_pc4; m_rd1 = in_rd1; m_rd2 = in_rd2; m_imm = in_imm;
      m_rs = in_rs; m_rt = in_rt; m_dst = in_ctl[12] ? in_rd : in_rt; m_known = 1;
    end
  endtask

  task automatic check_state(input string ph);
    chk({ph, "_valid"}, 32'(o_valid), 32'(m_valid));
    chk({ph, "_ctl"}, 32'(o_ctl), 32'(m_ctl));
    chk({ph, "_bub"}, 32'(o_bub), 32'(m_bub));
    if (m_known) begin
      chk({ph, "_pc4"}, o_pc4, m_pc4);
      chk({ph, "_rd1"}, o_rd1, m_rd1);
      chk({ph, "_rd2"}, o_rd2, m_rd2);
      chk({ph, "_imm"}, o_imm, m_imm);
      chk({ph, "_rs"}, 32'(o_rs), 32'(m_rs));
      chk({ph, "_rt"}, 32'(o_rt), 32'(m_rt));
      chk({ph, "_dst"}, 32'(o_dst), 32'(m_dst));
    end
  endtask

  // Called right after a negedge with inputs set; exp_stall<0 means model only
  task automatic step(input string ph, input int exp_stall);
    #1;
    chk({ph, "_stall_model"}, 32'(o_stall), 32'(model_hazard() && !in_flush));
    if (exp_stall >= 0) chk({ph, "_stall"}, 32'(o_stall), 32'(exp_stall));
    @(posedge clk);
    model_edge();
    #1;
    check_state(ph);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [12:0] c, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
    in_valid = v; in_ctl = c; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_pc4 = $urandom; in_rd1 = $urandom; in_rd2 = $urandom;
    in_flush = 0; in_hold = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Load something, then reset asynchronously mid-cycle with all inputs nonzero
    set_instr(1, C_LW, 5'd1, 5'd8, 5'd3, 32'h1234);
    step("preload", 0);
    set_instr(1, 13'h1FFF, 5'd8, 5'd8, 5'd8, 32'hFFFF_FFFF);
    in_hold = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ctl", 32'(o_ctl), 32'd0);
    chk("rst_dst", 32'(o_dst), 32'd0);
    chk("rst_pc4", o_pc4, 32'd0);
    chk("rst_bub", 32'(o_bub), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // ADDI pass-through
    set_instr(1, C_ADDI, 5'd3, 5'd5, 5'd7, 32'h0000_FFFF);
    step("addi", 0);
    chk("addi_dst", 32'(o_dst), 32'd5);
    chk("addi_imm", o_imm, 32'h0000_FFFF);
    chk("addi_valid", 32'(o_valid), 32'd1);

    // Load-use on rs: one bubble then the R-type enters
    set_instr(1, C_LW, 5'd2, 5'd8, 5'd0, 32'h4);
    step("lw8", 0);
    set_instr(1, C_RTYP, 5'd8, 5'd2, 5'd4, 32'h0);
    step("lu_bubble", 1);
    chk("lu_bubble_regwrite", 32'(o_regwrite), 32'd0);
    chk("lu_bubble_cnt", 32'(o_bub), 32'd1);
    step("lu_release", 0);
    chk("lu_release_dst", 32'(o_dst), 32'd4);

    // Load to $0 never stalls
    set_instr(1, C_LW, 5'd2, 5'd0, 5'd0, 32'h8);
    step("lw0", 0);
    set_instr(1, C_RTYP, 5'd0, 5'd0, 5'd4, 32'h0);
    step("zero_nostall", 0);

    // rt-use filter: ADDI rt is a destination, SW rt is a source
    set_instr(1, C_LW, 5'd2, 5'd9, 5'd0, 32'h8);
    step("lw9a", 0);
    set_instr(1, C_ADDI, 5'd1, 5'd9, 5'd0, 32'h1);
    step("addi_rt", 0);
    set_instr(1, C_LW, 5'd2, 5'd9, 5'd0, 32'h8);
    step("lw9b", 0);
    set_instr(1, C_SW, 5'd1, 5'd9, 5'd0, 32'h10);
    step("sw_rt", 1);
    step("sw_release", 0);

    // Flush beats load-use
    set_instr(1, C_LW, 5'd2, 5'd8, 5'd0, 32'h4);
    step("lw8f", 0);
    set_instr(1, C_RTYP, 5'd8, 5'd3, 5'd6, 32'h0);
    in_flush = 1;
    step("lu_flush", 0);
    chk("lu_flush_valid", 32'(o_valid), 32'd0);

    // Load-use held for 3 cycles, bubble on release
    set_instr(1, C_LW, 5'd2, 5'd8, 5'd0, 32'h4);
    step("lw8h", 0);
    set_instr(1, C_RTYP, 5'd8, 5'd3, 5'd6, 32'h0);
    in_hold = 1;
    for (int i = 0; i < 3; i++) step("lu_hold", 1);
    chk("lu_hold_memread", 32'(o_memread), 32'd1);
    in_hold = 0;
    step("hold_release", 1);
    step("hold_load", 0);
    chk("bub_total", 32'(o_bub), 32'd4);

    // Random traffic with a small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom % 10) < 8;
      in_ctl = 13'($urandom);
      in_ctl[10] = ($urandom % 5) < 2;
      in_rs = 5'($urandom % 4); in_rt = 5'($urandom % 4); in_rd = 5'($urandom % 4);
      in_pc4 = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_imm = $urandom;
      in_flush = ($urandom % 10) == 0;
      in_hold = ($urandom % 7) == 0;
      step("rand", -1);
    end

    // Saturation: 20 flushed valid instructions
    set_instr(1, C_ADDI, 5'd1, 5'd2, 5'd3, 32'h0);
    in_flush = 1;
    for (int i = 0; i < 20; i++) step("sat", 0);
    chk("sat_cnt", 32'(o_bub), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
